// File: rtl/lc3_sequencer.sv
// Multi-cycle LC-3 control FSM: fetch, decode, execute, memory and write-back sequencing.
// Optional memory-wait watchdog enabled by defining LC3_SEQ_TIMEOUT_EN.
module lc3_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [15:0] IR,
  input  logic [2:0]  NZP,
  input  logic        MEM_READY,
  output logic        MEM_RD,
  output logic        MEM_WE,
  output logic        MAR_LE,
  output logic        MAR_SEL,
  output logic        IR_LE,
  output logic        PC_LE,
  output logic [1:0]  PC_SEL,
  output logic        RD_LE,
  output logic        REG_Control,
  output logic [1:0]  ALU_OP,
  output logic        CC_LE,
  output logic        ILLEGAL,
  output logic        HALTED,
  output logic        MEM_ERR,
  output logic [2:0]  STATE
);

  typedef enum logic [2:0] {
    StFetch0 = 3'd0,
    StFetch1 = 3'd1,
    StDecode = 3'd2,
    StExec   = 3'd3,
    StMem    = 3'd4,
    StWb     = 3'd5,
    StHalt   = 3'd6
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] opcode;
  logic       is_st;
  logic       br_taken;
  logic       timeout;
  logic       unused_ir;

  assign opcode    = IR[15:12];
  assign is_st     = (opcode == 4'b0011);
  assign br_taken  = |(IR[11:9] & NZP);
  assign unused_ir = ^IR[8:0];

`ifdef LC3_SEQ_TIMEOUT_EN
  logic [3:0] wait_q;
  logic       mem_err_q;
  logic       in_wait;

  assign in_wait = (state_q == StFetch1) || (state_q == StMem);
  // Abort on the wait cycle that would bring the counter to the limit.
  assign timeout = in_wait && !MEM_READY && (wait_q == 4'(TIMEOUT_CYCLES - 1));
  assign MEM_ERR = mem_err_q;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      wait_q    <= 4'd0;
      mem_err_q <= 1'b0;
    end else begin
      if (in_wait && !MEM_READY) begin
        wait_q <= wait_q + 4'd1;
      end else begin
        wait_q <= 4'd0;
      end
      if (timeout) begin
        mem_err_q <= 1'b1;
      end
    end
  end
`else
  localparam int unsigned unused_timeout = TIMEOUT_CYCLES;
  assign timeout = 1'b0;
  assign MEM_ERR = 1'b0;
`endif

  always_comb begin
    state_d = StFetch0;
    case (state_q)
      StFetch0: state_d = StFetch1;
      StFetch1: begin
        if (MEM_READY)    state_d = StDecode;
        else if (timeout) state_d = StHalt;
        else              state_d = StFetch1;
      end
      StDecode: state_d = StExec;
      StExec: begin
        case (opcode)
          4'b0010, 4'b0011: state_d = StMem;
          4'b1111:          state_d = StHalt;
          default:          state_d = StFetch0;
        endcase
      end
      StMem: begin
        if (MEM_READY)    state_d = is_st ? StFetch0 : StWb;
        else if (timeout) state_d = StHalt;
        else              state_d = StMem;
      end
      StWb:    state_d = StFetch0;
      StHalt:  state_d = StHalt;
      default: state_d = StFetch0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= StFetch0;
    end else begin
      state_q <= state_d;
    end
  end

  // Reset gates every output combinationally so a pending request drops at once.
  always_comb begin
    MEM_RD      = 1'b0;
    MEM_WE      = 1'b0;
    MAR_LE      = 1'b0;
    MAR_SEL     = 1'b0;
    IR_LE       = 1'b0;
    PC_LE       = 1'b0;
    PC_SEL      = 2'd0;
    RD_LE       = 1'b0;
    REG_Control = 1'b0;
    ALU_OP      = 2'd0;
    CC_LE       = 1'b0;
    ILLEGAL     = 1'b0;
    HALTED      = 1'b0;
    STATE       = 3'd0;
    if (!RESET) begin
      STATE = state_q;
      case (state_q)
        StFetch0: MAR_LE = 1'b1;
        StFetch1: begin
          MEM_RD = 1'b1;
          IR_LE  = MEM_READY;
          PC_LE  = MEM_READY;
        end
        StExec: begin
          case (opcode)
            4'b0001: begin RD_LE = 1'b1; CC_LE = 1'b1; ALU_OP = 2'd0; end
            4'b0101: begin RD_LE = 1'b1; CC_LE = 1'b1; ALU_OP = 2'd1; end
            4'b1001: begin RD_LE = 1'b1; CC_LE = 1'b1; ALU_OP = 2'd2; end
            4'b0010, 4'b0011: begin MAR_LE = 1'b1; MAR_SEL = 1'b1; end
            4'b0000: begin
              PC_LE  = br_taken;
              PC_SEL = br_taken ? 2'd1 : 2'd0;
            end
            4'b1100: begin PC_LE = 1'b1; PC_SEL = 2'd2; end
            4'b1111: ;
            default: ILLEGAL = 1'b1;
          endcase
        end
        StMem: begin
          MEM_RD = !is_st;
          MEM_WE = is_st;
        end
        StWb: begin
          RD_LE       = 1'b1;
          REG_Control = 1'b1;
          CC_LE       = 1'b1;
        end
        StHalt:  HALTED = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lc3_sequencer.sv
// Scoreboard bench for lc3_sequencer: a per-instruction model expands each instruction into
// its expected cycle-by-cycle output trace; a monitor compares every cycle on the falling edge.
module tb_lc3_sequencer;

  localparam int unsigned TMO = 15;
`ifdef LC3_SEQ_TIMEOUT_EN
  localparam bit TimeoutOn = 1'b1;
`else
  localparam bit TimeoutOn = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic [15:0] IR = 16'h0;
  logic [2:0]  NZP = 3'b0;
  logic        MEM_READY = 1'b0;
  logic        MEM_RD, MEM_WE, MAR_LE, MAR_SEL, IR_LE, PC_LE, RD_LE, REG_Control;
  logic        CC_LE, ILLEGAL, HALTED, MEM_ERR;
  logic [1:0]  PC_SEL, ALU_OP;
  logic [2:0]  STATE;

  lc3_sequencer #(.TIMEOUT_CYCLES(TMO)) dut (
    .CLK(CLK), .RESET(RESET), .IR(IR), .NZP(NZP), .MEM_READY(MEM_READY),
    .MEM_RD(MEM_RD), .MEM_WE(MEM_WE), .MAR_LE(MAR_LE), .MAR_SEL(MAR_SEL), .IR_LE(IR_LE),
    .PC_LE(PC_LE), .PC_SEL(PC_SEL), .RD_LE(RD_LE), .REG_Control(REG_Control),
    .ALU_OP(ALU_OP), .CC_LE(CC_LE), .ILLEGAL(ILLEGAL), .HALTED(HALTED), .MEM_ERR(MEM_ERR),
    .STATE(STATE)
  );

  always #5 CLK = ~CLK;

  // Output vector layout, MSB first.
  localparam logic [19:0] M_RD = 20'h80000, M_WE = 20'h40000, M_MARLE = 20'h20000;
  localparam logic [19:0] M_MARSEL = 20'h10000, M_IRLE = 20'h08000, M_PCLE = 20'h04000;
  localparam logic [19:0] M_PC1 = 20'h01000, M_PC2 = 20'h02000, M_RDLE = 20'h00800;
  localparam logic [19:0] M_REGC = 20'h00400, M_ALU1 = 20'h00100, M_ALU2 = 20'h00200;
  localparam logic [19:0] M_CC = 20'h00080, M_ILL = 20'h00040, M_HALT = 20'h00020;
  localparam logic [19:0] M_ERR = 20'h00010;

  logic [19:0] act;
  assign act = {MEM_RD, MEM_WE, MAR_LE, MAR_SEL, IR_LE, PC_LE, PC_SEL, RD_LE, REG_Control,
                ALU_OP, CC_LE, ILLEGAL, HALTED, MEM_ERR, 1'b0, STATE};

  typedef struct {
    logic        rst;
    logic [15:0] ir;
    logic [2:0]  nzp;
    logic        rdy;
    logic [19:0] exp;
  } cyc_t;

  cyc_t        stim_q[$];
  logic [19:0] exp_q[$];
  int          tests = 0;
  int          fails = 0;
  int          cycle = 0;
  logic [15:0] cur_ir;
  logic [2:0]  cur_nzp;
  bit          err_m = 1'b0;

  function automatic logic rnd();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic push(input int st, input logic [19:0] bits, input logic rdy);
    cyc_t c;
    c.rst = 1'b0;
    c.ir  = cur_ir;
    c.nzp = cur_nzp;
    c.rdy = rdy;
    c.exp = bits | (err_m ? M_ERR : 20'h0) | 20'(st);
    stim_q.push_back(c);
  endtask

  // While reset is high every output is zero; MEM_ERR only clears at the first reset edge.
  task automatic push_reset(input int n);
    cyc_t c;
    for (int i = 0; i < n; i++) begin
      c.rst = 1'b1;
      c.ir  = 16'($urandom);
      c.nzp = 3'($urandom);
      c.rdy = rnd();
      c.exp = err_m ? M_ERR : 20'h0;
      err_m = 1'b0;
      stim_q.push_back(c);
    end
  endtask

  task automatic push_halt(input int n);
    for (int i = 0; i < n; i++) push(6, M_HALT, rnd());
  endtask

  task automatic push_wait(input int st, input logic [19:0] bits, input int waits,
                           output bit to);
    to = 1'b0;
    for (int i = 0; i < waits; i++) begin
      push(st, bits, 1'b0);
      if (TimeoutOn && (i + 1 == int'(TMO))) begin
        to = 1'b1;
        err_m = 1'b1;
        return;
      end
    end
  endtask

  task automatic instr(input logic [15:0] ir, input logic [2:0] nzp, input int wf,
                       input int wm, input int halt_cyc);
    bit          to;
    logic [19:0] mb;
    cur_ir  = ir;
    cur_nzp = nzp;
    push(0, M_MARLE, rnd());
    push_wait(1, M_RD, wf, to);
    if (to) begin
      push_halt(halt_cyc);
      push_reset(1);
      return;
    end
    push(1, M_RD | M_IRLE | M_PCLE, 1'b1);
    push(2, 20'h0, rnd());
    case (ir[15:12])
      4'd1:  push(3, M_RDLE | M_CC, rnd());
      4'd5:  push(3, M_RDLE | M_CC | M_ALU1, rnd());
      4'd9:  push(3, M_RDLE | M_CC | M_ALU2, rnd());
      4'd0:  push(3, ((ir[11:9] & nzp) != 3'b0) ? (M_PCLE | M_PC1) : 20'h0, rnd());
      4'd12: push(3, M_PCLE | M_PC2, rnd());
      4'd2, 4'd3: begin
        push(3, M_MARLE | M_MARSEL, rnd());
        mb = (ir[15:12] == 4'd3) ? M_WE : M_RD;
        push_wait(4, mb, wm, to);
        if (to) begin
          push_halt(halt_cyc);
          push_reset(1);
          return;
        end
        push(4, mb, 1'b1);
        if (ir[15:12] == 4'd2) push(5, M_RDLE | M_REGC | M_CC, rnd());
      end
      4'd15: begin
        push(3, 20'h0, rnd());
        push_halt(halt_cyc);
        push_reset($urandom_range(1, 3));
      end
      default: push(3, M_ILL, rnd());
    endcase
  endtask

  // Abandon an instruction while it waits in fetch.
  task automatic mid_reset(input int waits, input int rst_cyc);
    cur_ir = 16'($urandom);
    push(0, M_MARLE, rnd());
    for (int i = 0; i < waits; i++) push(1, M_RD, 1'b0);
    push_reset(rst_cyc);
  endtask

  always @(negedge CLK) begin
    logic [19:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      tests++;
      if (act !== e) begin
        fails++;
        $display("FAIL cycle %0d outputs: got %h expected %h", cycle, act, e);
      end
      cycle++;
    end
  end

  initial begin
    cyc_t c;
    logic [3:0] op;
    push_reset(2);
    mid_reset(2, 3);
    instr(16'h1042, 3'b000, 0, 0, 1);
    instr(16'h2205, 3'b001, 0, 3, 1);
    instr(16'h0A03, 3'b010, 0, 0, 1);
    instr(16'h0A03, 3'b100, 1, 0, 1);
    instr(16'h3A10, 3'b001, 2, 2, 1);
    instr(16'h5123, 3'b010, 0, 0, 1);
    instr(16'h907F, 3'b010, 0, 0, 1);
    instr(16'hC1C0, 3'b001, 0, 0, 1);
    instr(16'hD000, 3'b001, 0, 0, 1);
    instr(16'h1042, 3'b001, 0, 0, 1);
    instr(16'hF025, 3'b001, 0, 0, 20);
    instr(16'h1042, 3'b000, 40, 0, 5);
    for (int n = 0; n < 250; n++) begin
      if ($urandom_range(0, 19) == 0) mid_reset($urandom_range(0, 3), $urandom_range(1, 3));
      op = 4'($urandom);
      instr({op, 12'($urandom)}, 3'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
            $urandom_range(1, 4));
    end

    while (stim_q.size() > 0) begin
      @(posedge CLK);
      #1;
      c = stim_q.pop_front();
      RESET     = c.rst;
      IR        = c.ir;
      NZP       = c.nzp;
      MEM_READY = c.rdy;
      exp_q.push_back(c.exp);
    end
    repeat (3) @(negedge CLK);
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/lc3_sequencer.md
# lc3_sequencer

Multi-cycle control FSM for the LC-3 datapath. It sequences fetch, decode, execute, memory and write-back for a core instruction subset. It drives the register-file write enable and write-data select, the ALU op, the PC/MAR/IR load strobes and the memory handshake. It sits beside the register-file wrapper and consumes IR and the condition codes.

## Interface
- TIMEOUT_CYCLES, 15: memory-wait watchdog limit in cycles; used only with LC3_SEQ_TIMEOUT_EN.
- CLK  in  1  system clock; all state changes on the rising edge.
- RESET  in  1  synchronous, active-high reset.
- IR  in  16  current instruction; opcode is IR[15:12], nzp is IR[11:9].
- NZP  in  3  condition-code register {N,Z,P}.
- MEM_READY  in  1  memory completes the current read or write this cycle.
- MEM_RD  out  1  memory read request, held until MEM_READY.
- MEM_WE  out  1  memory write request, held until MEM_READY.
- MAR_LE  out  1  load MAR.
- MAR_SEL  out  1  MAR source: 0 = PC, 1 = PC+SEXT(IR[8:0]).
- IR_LE  out  1  load IR from memory data.
- PC_LE  out  1  load PC.
- PC_SEL  out  2  PC source: 0 = PC+1, 1 = PC+SEXT(IR[8:0]), 2 = base register (RS1_DATA).
- RD_LE  out  1  register-file write enable.
- REG_Control  out  1  register write-data select: 0 = ALU result, 1 = memory data.
- ALU_OP  out  2  ALU operation: 0 = ADD, 1 = AND, 2 = NOT.
- CC_LE  out  1  update the condition codes.
- ILLEGAL  out  1  one-cycle pulse on an unsupported opcode.
- HALTED  out  1  high in the HALT state.
- MEM_ERR  out  1  sticky watchdog-abort flag.
- STATE  out  3  current state, for debug.

## Operation
- State encodings: FETCH0=0, FETCH1=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6. Encoding 7 is unreachable and maps to FETCH0.
- FETCH0: MAR_LE=1, MAR_SEL=0; go to FETCH1.
- FETCH1: MEM_RD=1.
  - If MEM_READY=0, stay in FETCH1.
  - If MEM_READY=1: IR_LE=1, PC_LE=1, PC_SEL=0, then go to DECODE.
- DECODE: no strobes; go to EXEC.
- EXEC, by opcode:
  - ADD (0001), AND (0101), NOT (1001): RD_LE=1, REG_Control=0, CC_LE=1, ALU_OP=0/1/2 respectively; go to FETCH0.
  - LD (0010), ST (0011): MAR_LE=1, MAR_SEL=1; go to MEM.
  - BR (0000): if |(IR[11:9] & NZP), then PC_LE=1, PC_SEL=1. Go to FETCH0.
  - JMP (1100): PC_LE=1, PC_SEL=2; go to FETCH0.
  - TRAP (1111): go to HALT.
  - Any other opcode: ILLEGAL=1 for one cycle; go to FETCH0, so the instruction executes as a NOP.
- MEM:
  - LD: MEM_RD=1 until MEM_READY, then go to WB.
  - ST: MEM_WE=1 until MEM_READY, then go to FETCH0.
- WB: RD_LE=1, REG_Control=1, CC_LE=1; go to FETCH0.
- HALT: HALTED=1 and all strobes are 0. Only RESET leaves this state.
- Output style:
  - All outputs are decoded from the state register and IR.
  - IR_LE and PC_LE in FETCH1 also depend combinationally on MEM_READY.
  - Every output not listed for a state is 0.
- MEM_RD and MEM_WE are never asserted together.

## Timing
- Reset:
  - While RESET is sampled high, the next state is FETCH0 and MEM_ERR clears.
  - While RESET is high, all strobes are forced to 0 combinationally, so a pending MEM_RD/MEM_WE drops in the same cycle.
  - Outputs during reset: STATE=0, HALTED=0, ILLEGAL=0, ALU_OP=0, PC_SEL=0, MAR_SEL=0, REG_Control=0.
- Reset mid-operation: an in-flight instruction is abandoned without a write-back. The first cycle after RESET falls is FETCH0.
- Latency with MEM_READY returned in the first wait cycle:
  - ALU, BR, JMP: 4 cycles.
  - ST: 5 cycles.
  - LD: 6 cycles.
  - Each wait cycle adds 1.
- MEM_READY is ignored in every state except FETCH1 and MEM.
- BR and JMP take effect after the PC+1 update: the FETCH1 increment comes first, and the EXEC load overrides it.

## Configuration
- LC3_SEQ_TIMEOUT_EN defined:
  - A 4-bit wait counter clears on entry to FETCH1 or MEM and increments each wait cycle.
  - If the counter reaches TIMEOUT_CYCLES with MEM_READY still low, the FSM goes to HALT and sets MEM_ERR=1.
  - MEM_ERR stays set until RESET.
- LC3_SEQ_TIMEOUT_EN undefined: no counter; waits are unbounded and MEM_ERR is tied to 0.

## Test plan
- RESET held 3 cycles mid-FETCH1 -> MEM_RD=0 while RESET is high; STATE=0, MAR_LE=1 in the first cycle after release.
- IR=0x1042 (ADD) with MEM_READY always high -> RD_LE=1, REG_Control=0, ALU_OP=0, CC_LE=1 in cycle 4; STATE returns to 0 in cycle 5.
- IR=0x2205 (LD) with MEM_READY delayed 3 cycles in MEM -> MEM_RD held for 3 cycles, then WB with RD_LE=1, REG_Control=1; total 9 cycles.
- IR=0x0A03 (BRnp): NZP=3'b010 -> PC_LE=0 in EXEC; NZP=3'b100 -> PC_LE=1, PC_SEL=1.
- IR=0xD000 (reserved) -> ILLEGAL pulses once; next fetch proceeds. IR=0xF025 -> HALTED=1, stays 1 for 20 cycles regardless of MEM_READY.
- With LC3_SEQ_TIMEOUT_EN and MEM_READY=0 forever -> HALT after 15 wait cycles, MEM_ERR=1; without the macro -> remains in FETCH1 with MEM_RD=1.
